// File: rtl/comm_recv_sched.sv
// comm_recv_sched: receive-path scheduler between the sample FIFO and the
// 64-point FFT. Tracks FIFO occupancy and, once a frame is started, releases
// one OFDM symbol at a time: cyclic prefix dropped, then NFFT gap-free
// samples streamed to the FFT. Counts symbols, flags frame end and overflow.
module comm_recv_sched #(
    parameter int NFFT  = 64,
    parameter int CP    = 16,
    parameter int SYMS  = 8,
    parameter int DEPTH = 256,
    parameter int LVL_W = 9,
    parameter int SYM_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             fifo_wr,
    output logic             fifo_rd_en,
    output logic             fft_valid,
    input  logic             fft_ready,
    output logic             sym_start,
    output logic [SYM_W-1:0] sym_idx,
    output logic             frame_done,
    output logic             busy,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    // The run counter has to reach the longer of the CP and NFFT phases.
    localparam int CNT_MAX = (NFFT > CP) ? NFFT : CP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DROP,
        S_BURST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYM_W-1:0]   sym_idx_q, sym_idx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic               frame_done_q;
    logic               busy_q;
    logic               popNow;
    logic               fftNow;
    logic               symFirst;
    logic               levelOk;

    // A symbol may only start once the whole CP+NFFT run is already buffered,
    // which is what makes the run gap-free without watching the level later.
    assign levelOk = (int'(level_q) >= CP + NFFT);

    // Next-state, counters and the pop/valid strobes decoded from state/cnt.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_idx_d = sym_idx_q;
        popNow    = 1'b0;
        fftNow    = 1'b0;
        symFirst  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    sym_idx_d = '0;
                end
            end
            S_WAIT: begin
                if (levelOk && fft_ready) begin
                    cnt_d   = '0;
                    state_d = (CP == 0) ? S_BURST : S_DROP;
                end
            end
            S_DROP: begin
                popNow = 1'b1;
                if (int'(cnt_q) == CP - 1) begin
                    cnt_d   = '0;
                    state_d = S_BURST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BURST: begin
                popNow   = 1'b1;
                fftNow   = 1'b1;
                symFirst = (cnt_q == '0);
                if (int'(cnt_q) == NFFT - 1) begin
                    cnt_d = '0;
                    if (int'(sym_idx_q) == SYMS - 1) begin
                        state_d = S_DONE;
                    end else begin
                        sym_idx_d = sym_idx_q + SYM_W'(1);
                        state_d   = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort beats everything, including a start seen in IDLE, and gates
        // the strobes in the same cycle so no sample leaves the FIFO.
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            sym_idx_d = sym_idx_q;
            popNow    = 1'b0;
            fftNow    = 1'b0;
            symFirst  = 1'b0;
        end
    end

    // Occupancy tracking; a write into a full FIFO is lost and latches overflow.
    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        if (fifo_wr && !popNow) begin
            if (int'(level_q) == DEPTH) begin
                overflow_d = 1'b1;
            end else begin
                level_d = level_q + LVL_W'(1);
            end
        end else if (!fifo_wr && popNow) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // State and status registers; busy/frame_done are registered from state_d.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sym_idx_q    <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sym_idx_q    <= sym_idx_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            frame_done_q <= (state_d == S_DONE);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign fifo_rd_en = popNow;
    assign fft_valid  = fftNow;
    assign sym_start  = symFirst;
    assign sym_idx    = sym_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign level      = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_comm_recv_sched.sv
// tb_comm_recv_sched: bench for comm_recv_sched (SYMS=2). A behavioural model
// describes each symbol as a countdown of CP+NFFT pops and checks every
// output every cycle; directed scenarios pin the model with literal numbers.
module tb_comm_recv_sched;

    localparam int NFFT  = 64;
    localparam int CP    = 16;
    localparam int SYMS  = 2;
    localparam int DEPTH = 256;
    localparam int LVL_W = 9;
    localparam int SYM_W = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             fifo_wr = 1'b0;
    logic             fft_ready = 1'b0;
    logic             fifo_rd_en;
    logic             fft_valid;
    logic             sym_start;
    logic [SYM_W-1:0] sym_idx;
    logic             frame_done;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             overflow;

    always #5 CLK = ~CLK;

    comm_recv_sched #(
        .NFFT(NFFT), .CP(CP), .SYMS(SYMS), .DEPTH(DEPTH), .LVL_W(LVL_W), .SYM_W(SYM_W)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .fifo_wr(fifo_wr),
        .fifo_rd_en(fifo_rd_en), .fft_valid(fft_valid), .fft_ready(fft_ready),
        .sym_start(sym_start), .sym_idx(sym_idx), .frame_done(frame_done),
        .busy(busy), .level(level), .overflow(overflow)
    );

    int nVec = 0;
    int nFail = 0;

    // Model: mRun counts pops left in the current symbol run (0 = waiting).
    int mLevel, mRun, mSym;
    bit mBusy, mDone, mOvf;

    // Values sampled from the DUT in the last checked cycle.
    bit sRd, sValid, sSS, sDone, sBusy, sOvf;
    int sLevel, sIdx;

    // Statistics gathered by observe() for the directed pins.
    int cyc, rdRun, gapRun, vRun, firstValid, firstRd, totalRd, totalValid, doneCount;
    int cycLevel80, levelAtRunEnd;
    int runLens[$];
    int gaps[$];
    int ssPos[$];
    int validLens[$];

    // Single comparison with failure report.
    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic checkOutput();
        bit ePop, eValid, eSS;
        ePop   = (mRun > 0) && !abort;
        eValid = ePop && (mRun <= NFFT);
        eSS    = ePop && (mRun == NFFT);
        sRd    = fifo_rd_en;
        sValid = fft_valid;
        sSS    = sym_start;
        sDone  = frame_done;
        sBusy  = busy;
        sOvf   = overflow;
        sLevel = int'(level);
        sIdx   = int'(sym_idx);
        nVec++;
        cmp("fifo_rd_en", int'(sRd), int'(ePop));
        cmp("fft_valid", int'(sValid), int'(eValid));
        cmp("sym_start", int'(sSS), int'(eSS));
        cmp("frame_done", int'(sDone), int'(mDone));
        cmp("busy", int'(sBusy), int'(mBusy));
        cmp("overflow", int'(sOvf), int'(mOvf));
        cmp("level", sLevel, mLevel);
        cmp("sym_idx", sIdx, mSym);
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic modelEdge();
        bit pop;
        int oldLevel;
        pop      = (mRun > 0) && !abort;
        oldLevel = mLevel;
        if (fifo_wr && !pop) begin
            if (mLevel == DEPTH) mOvf = 1'b1;
            else mLevel++;
        end else if (pop && !fifo_wr) begin
            mLevel--;
        end
        if (abort) begin
            mBusy = 1'b0; mRun = 0; mDone = 1'b0;
        end else if (mDone) begin
            mDone = 1'b0; mBusy = 1'b0;
        end else if (!mBusy) begin
            if (start) begin
                mBusy = 1'b1; mSym = 0; mRun = 0;
            end
        end else if (mRun == 0) begin
            if (oldLevel >= CP + NFFT && fft_ready) mRun = CP + NFFT;
        end else begin
            mRun--;
            if (mRun == 0) begin
                if (mSym == SYMS - 1) mDone = 1'b1;
                else mSym++;
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs, then step the model.
    task automatic applyStimulus(input bit s, input bit a, input bit w, input bit r);
        @(negedge CLK);
        start = s; abort = a; fifo_wr = w; fft_ready = r;
        #1;
        checkOutput();
        @(posedge CLK);
        modelEdge();
    endtask

    // Assert reset asynchronously away from the edge, check, then release.
    task automatic doReset();
        @(negedge CLK);
        RST = 1'b0; start = 1'b0; abort = 1'b0; fifo_wr = 1'b0; fft_ready = 1'b0;
        #1;
        mLevel = 0; mRun = 0; mSym = 0; mBusy = 1'b0; mDone = 1'b0; mOvf = 1'b0;
        checkOutput();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic clearStats();
        cyc = 0; rdRun = 0; gapRun = 0; vRun = 0; firstValid = -1; firstRd = -1;
        totalRd = 0; totalValid = 0; doneCount = 0; cycLevel80 = -1; levelAtRunEnd = -1;
        runLens.delete(); gaps.delete(); ssPos.delete(); validLens.delete();
    endtask

    // Fold the sampled cycle into run/gap/valid statistics.
    task automatic observe();
        if (sLevel == 80 && cycLevel80 < 0) cycLevel80 = cyc;
        if (sRd) begin
            if (firstRd < 0) firstRd = cyc;
            totalRd++;
            rdRun++;
            if (sSS) ssPos.push_back(rdRun);
            if (rdRun == CP + NFFT && runLens.size() == 0) levelAtRunEnd = sLevel;
            if (runLens.size() > 0 && gapRun > 0) gaps.push_back(gapRun);
            gapRun = 0;
        end else begin
            if (rdRun > 0) runLens.push_back(rdRun);
            rdRun = 0;
            if (runLens.size() > 0) gapRun++;
        end
        if (sValid) begin
            if (firstValid < 0) firstValid = cyc;
            totalValid++;
            vRun++;
        end else begin
            if (vRun > 0) validLens.push_back(vRun);
            vRun = 0;
        end
        if (sDone) doneCount++;
        cyc++;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Run with fft_ready high until the frame ends; an expired budget fails.
    task automatic runFrame(input bit writes, input int budget);
        int k;
        k = 0;
        while (!(doneCount > 0 && !sBusy) && k < budget) begin
            applyStimulus(1'b0, 1'b0, writes, 1'b1);
            observe();
            k++;
        end
        if (k >= budget) cmp("frame_timeout", 0, 1);
    endtask

    initial begin
        int k;
        // Reset and first write.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("first_write_level", sLevel, 1);
        cmp("reset_busy", int'(sBusy), 0);

        // Overflow: 257 writes with no reads.
        doReset();
        preload(257);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("ovf_level", sLevel, 256);
        cmp("ovf_flag", int'(sOvf), 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("ovf_sticky", int'(sOvf), 1);

        // Normal frame from a 200-sample preload.
        doReset();
        preload(200);
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        observe();
        runFrame(1'b0, 400);
        cmp("norm_run0", (runLens.size() > 0) ? runLens[0] : -1, 80);
        cmp("norm_run1", (runLens.size() > 1) ? runLens[1] : -1, 80);
        cmp("norm_gap", (gaps.size() > 0) ? gaps[0] : -1, 1);
        cmp("norm_sspos", (ssPos.size() > 0) ? ssPos[0] : -1, 17);
        cmp("norm_valid", totalValid, 128);
        cmp("norm_first_valid", firstValid, 18);
        cmp("norm_done_count", doneCount, 1);
        cmp("norm_level", sLevel, 40);

        // Starvation: 50 buffered, then one write per cycle.
        doReset();
        preload(50);
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        observe();
        runFrame(1'b1, 600);
        cmp("starve_drop_delay", firstRd - cycLevel80, 1);
        cmp("starve_valid0", (validLens.size() > 0) ? validLens[0] : -1, 64);
        cmp("starve_valid1", (validLens.size() > 1) ? validLens[1] : -1, 64);
        cmp("starve_wr_pop_level", levelAtRunEnd, 81);

        // Backpressure: fft_ready low for 30 cycles.
        doReset();
        preload(200);
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        observe();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            observe();
        end
        cmp("bp_no_pops", totalRd, 0);
        runFrame(1'b0, 400);
        cmp("bp_first_pop", firstRd, 32);

        // Abort right after the 10th valid sample of the first symbol.
        doReset();
        preload(200);
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        observe();
        k = 0;
        while (totalValid < 10 && k < 200) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            observe();
            k++;
        end
        if (k >= 200) cmp("abort1_timeout", 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        observe();
        cmp("abort_rd_gate", int'(sRd), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            observe();
        end
        cmp("abort_busy", int'(sBusy), 0);
        cmp("abort_no_done", doneCount, 0);
        cmp("abort_level", sLevel, 174);

        // Abort in the second symbol, then restart from sym_idx 0.
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        observe();
        k = 0;
        while (totalValid < NFFT + 10 && k < 300) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            observe();
            k++;
        end
        if (k >= 300) cmp("abort2_timeout", 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("abort2_level", sLevel, 68);
        cmp("abort2_idx_hold", sIdx, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("restart_idx", sIdx, 0);
        cmp("restart_busy", int'(sBusy), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

        // Randomised traffic with a reset dropped in mid-stream.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) doReset();
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 55, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
